uart_mem_bridge: RTL
====================

# uart_mem_bridge

Parametrised UART-to-memory command bridge. It sits between a `uart_rx`/`uart_tx` pair and a memory port such as the program RAM's loader port. It parses byte-stream write (`W`) and read (`R`) commands with configurable address and data widths, issues single-cycle memory strobes, and returns a write acknowledge or read data bytes over a valid/ready transmit handshake. An inter-byte timeout aborts partial commands.

## Interface
Parameters:
- `ADDR_BYTES`, default 4: address bytes per command (1–4); `mem_addr_out` is `8*ADDR_BYTES` bits wide.
- `DATA_BYTES`, default 4: data bytes per command (1–8); `mem_wdata_out`/`mem_rdata_in` are `8*DATA_BYTES` bits wide.
- `TIMEOUT_CYCLES`, default 65535: idle cycles allowed between bytes of one command (≥2).

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rx_data_in`  in  8  received byte.
- `rx_valid_in`  in  1  one-cycle pulse qualifying `rx_data_in`.
- `mem_addr_out`  out  8*ADDR_BYTES  access address.
- `mem_wdata_out`  out  8*DATA_BYTES  write data.
- `mem_we_out`  out  1  one-cycle write strobe.
- `mem_re_out`  out  1  one-cycle read strobe.
- `mem_rdata_in`  in  8*DATA_BYTES  read data.
- `mem_rvalid_in`  in  1  qualifies `mem_rdata_in`, any number of cycles (≥1) after `mem_re_out`.
- `tx_data_out`  out  8  byte to transmitter.
- `tx_valid_out`  out  1  byte valid.
- `tx_ready_in`  in  1  transmitter accepts byte.
- `busy_out`  out  1  high in every state except IDLE.
- `err_out`  out  1  one-cycle pulse on timeout or dropped byte.

## Operation
- States: IDLE, ADDR, DATA, MEM_WAIT, RESP.
- IDLE, on `rx_valid_in`:
  - 0x57 (`W`) → ADDR with op=write.
  - 0x52 (`R`) → ADDR with op=read.
  - Any other byte is silently ignored; no `err_out`.
- Byte order is big-endian: the first byte received is the MSB. The byte counter counts exactly `ADDR_BYTES`, then exactly `DATA_BYTES`.
- ADDR: shift bytes into the address register.
  - After the last byte, if op=write → DATA.
  - If op=read → pulse `mem_re_out` and go to MEM_WAIT.
- DATA: shift bytes into the data register. After the last byte, pulse `mem_we_out` and go to RESP with a single ack byte 0x4B (`K`).
- MEM_WAIT: capture `mem_rdata_in` on `mem_rvalid_in` → RESP with `DATA_BYTES` bytes, MSB first. This state has no timeout. `mem_rvalid_in` is ignored in every other state.
- RESP:
  - Drive `tx_valid_out` with the current byte.
  - Advance on `tx_valid_out && tx_ready_in`.
  - After the last accepted byte → IDLE.
- Timeout: a counter clears on entry to ADDR and on every accepted byte in ADDR/DATA. When it reaches `TIMEOUT_CYCLES`:
  - return to IDLE and pulse `err_out`;
  - issue no strobe and send no response.
- `rx_valid_in` in MEM_WAIT or RESP: the byte is dropped and `err_out` pulses. State is unaffected.
- `mem_addr_out` and `mem_wdata_out` are not zeroed between commands. They hold their last shifted values; consumers qualify them with the strobes only.

## Timing
- Reset (async assert): state=IDLE, all counters 0. All outputs are 0: `mem_addr_out`, `mem_wdata_out`, `mem_we_out`, `mem_re_out`, `tx_data_out`, `tx_valid_out`, `busy_out`, `err_out`.
- Reset mid-command aborts it with no strobe issued.
- All outputs are registered.
- Strobe latency:
  - `mem_we_out` / `mem_re_out` is high in the cycle after the clock edge that samples the last command byte.
  - `mem_addr_out` / `mem_wdata_out` are final in that same cycle.
- Write ack: `tx_valid_out` rises in the cycle after `mem_we_out`.
- Read: `tx_valid_out` rises in the cycle after `mem_rvalid_in` is sampled.
- While `tx_valid_out && !tx_ready_in`, `tx_data_out` and `tx_valid_out` are held stable.
- A new byte is presented in the cycle after acceptance. `tx_valid_out` stays high across consecutive bytes if `tx_ready_in` stays high.
- Timeout and `rx_valid_in` in the same cycle: the byte wins and the counter clears.
- Back-to-back commands: a `W` byte arriving in the cycle after RESP→IDLE is accepted.

## Test plan
- Write command, `ADDR_BYTES=4`, `DATA_BYTES=4`: send 57 00 02 00 10 DE AD BE EF.
  - Expect one `mem_we_out` pulse with addr=0x00020010, data=0xDEADBEEF.
  - Then `tx_data_out`=0x4B accepted once.
- Read command: send 52 00 02 00 10. Expect one `mem_re_out` pulse with addr=0x00020010. Return `mem_rdata_in`=0x12345678 after 3 cycles.
  - Expect tx bytes 12, 34, 56, 78 in order.
  - Toggle `tx_ready_in` low for 2 cycles mid-stream and check the held byte stays stable.
- Timeout with `TIMEOUT_CYCLES`=16: send 57 01 02, then idle 16 cycles.
  - Expect one `err_out` pulse, return to IDLE, no strobe.
  - A following full write completes normally.
- Noise and drops:
  - Send 00 FF 41 in IDLE: no strobe, no `err_out`.
  - Send a byte during MEM_WAIT: one `err_out` pulse, and the read still completes with the correct data.
- Async `rst_in` asserted after the 6th byte of a write: all outputs go to 0 immediately. No `mem_we_out` follows. A subsequent command works.
- Parameter sweep: `ADDR_BYTES=2`, `DATA_BYTES=1`. Send 57 AB CD 5A: expect addr=0xABCD, data=0x5A, ack 0x4B.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//   Parses big-endian byte-stream commands from a UART receiver and turns
//   them into single-cycle memory strobes, returning an ack or read data
//   bytes over a valid/ready transmit handshake.
//     'W' <addr bytes> <data bytes> : write, responds with 'K' (0x4B)
//     'R' <addr bytes>              : read,  responds with DATA_BYTES bytes
//   A partial command that goes quiet for TIMEOUT_CYCLES aborts with err_out.
// Ports
//   clk_in, rst_in                 clock, async active-high reset
//   rx_data_in/rx_valid_in         received byte + one-cycle qualifier
//   mem_addr_out/mem_wdata_out     access address / write data (held between commands)
//   mem_we_out/mem_re_out          one-cycle write / read strobes
//   mem_rdata_in/mem_rvalid_in     read return data + qualifier
//   tx_data_out/tx_valid_out       byte to transmitter, held until tx_ready_in
//   busy_out                       high whenever not idle
//   err_out                        one-cycle pulse on timeout or dropped byte
module uart_mem_bridge #(
  parameter int ADDR_BYTES     = 4,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_valid_in,
  output logic [8*ADDR_BYTES-1:0] mem_addr_out,
  output logic [8*DATA_BYTES-1:0] mem_wdata_out,
  output logic                    mem_we_out,
  output logic                    mem_re_out,
  input  logic [8*DATA_BYTES-1:0] mem_rdata_in,
  input  logic                    mem_rvalid_in,
  output logic [7:0]              tx_data_out,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic                    busy_out,
  output logic                    err_out
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [3:0]      cnt_q, cnt_d;        // bytes received, or bytes still to send in RESP
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rsp_q, rsp_d;        // remaining read bytes, next one at the top
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      op_wr_q    <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_q      <= rsp_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid_in && (rx_data_in == 8'h57 || rx_data_in == 8'h52)) begin
          op_wr_d = (rx_data_in == 8'h57);
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rx_valid_in) begin
          addr_d = (addr_q << 8) | AW'(rx_data_in);
          tmo_d  = '0;
          if (cnt_q == 4'(ADDR_BYTES - 1)) begin
            cnt_d = '0;
            if (op_wr_q) begin
              state_d = S_DATA;
            end else begin
              re_d    = 1'b1;
              state_d = S_MEM_WAIT;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DATA: begin
        if (rx_valid_in) begin
          wdata_d = (wdata_q << 8) | DW'(rx_data_in);
          tmo_d   = '0;
          if (cnt_q == 4'(DATA_BYTES - 1)) begin
            // Ack byte is loaded now but only raised as valid one cycle
            // later, so it trails the write strobe.
            we_d      = 1'b1;
            tx_data_d = 8'h4B;
            cnt_d     = '0;
            state_d   = S_RESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_MEM_WAIT: begin
        if (rx_valid_in) err_d = 1'b1;
        if (mem_rvalid_in) begin
          tx_data_d  = mem_rdata_in[DW-1 -: 8];
          rsp_d      = mem_rdata_in << 8;
          tx_valid_d = 1'b1;
          cnt_d      = 4'(DATA_BYTES - 1);
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (rx_valid_in) err_d = 1'b1;
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (tx_ready_in) begin
          if (cnt_q == '0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = rsp_q[DW-1 -: 8];
            rsp_d     = rsp_q << 8;
            cnt_d     = cnt_q - 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign mem_we_out    = we_q;
  assign mem_re_out    = re_q;
  assign tx_data_out   = tx_data_q;
  assign tx_valid_out  = tx_valid_q;
  assign busy_out      = busy_q;
  assign err_out       = err_q;

endmodule
